// File: rtl/hwag_regbus_arb.sv
`default_nettype none
// ============================================================================
//  Module   : hwag_regbus_arb
//  Purpose  : Register-bus master for the hwag block. After reset (or a
//             reinit pulse) it copies default values from an external ROM
//             into registers 0..LAST_ADDR, one write per cycle. With
//             HWAG_REGBUS_VERIFY_EN defined, it then reads every register
//             back and flags any mismatch on verr. Once booted, it serves
//             single host (SPI-side) read/write requests on the same bus.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: HWAG_REGBUS_VERIFY_EN (readback verify after load)
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          clock / asynchronous active-low reset
//    reinit            one-cycle pulse, restart the boot load
//    init_addr/data    external default-value ROM (combinational data)
//    host_req/we/addr/wdata  host request, held until host_ack
//    host_ack/rdata    one-cycle completion pulse, read data valid with ack
//    bus_addr/wdata/we/re    register-bus master outputs
//    bus_rdata         register read data, valid the cycle after bus_re
//    init_done, verr   boot complete / readback mismatch seen
// ============================================================================
module hwag_regbus_arb #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int LAST_ADDR = 130
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reinit,
    output logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              init_done,
    output logic              verr
);

    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] ONE_K  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_LOAD     = 3'd0,
        S_IDLE     = 3'd1,
        S_HWR      = 3'd2,
        S_HRD      = 3'd3,
        S_HRD_WAIT = 3'd4
`ifdef HWAG_REGBUS_VERIFY_EN
        , S_VERIFY = 3'd5
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic              run_q;          // low only until the first edge after reset
    logic              pend_q, pend_d; // reinit waiting for IDLE
    logic              done_q, done_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rack_q, rack_d; // read completion ack
    logic              restart;        // reinit accepted this cycle

`ifdef HWAG_REGBUS_VERIFY_EN
    logic              vdrain_q, vdrain_d; // final compare cycle after last read
    logic              chk_q, chk_d;       // bus_rdata this cycle is a verify read
    logic [DATA_W-1:0] exp_q, exp_d;       // ROM value of the address read last cycle
    logic              verr_q, verr_d;
`endif

    assign init_addr  = k_q;
    assign init_done  = done_q;
    assign host_rdata = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_LOAD;
            k_q      <= '0;
            run_q    <= 1'b0;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
            haddr_q  <= '0;
            hwdata_q <= '0;
            rdata_q  <= '0;
            rack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            run_q    <= 1'b1;
            pend_q   <= pend_d;
            done_q   <= done_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
            rack_q   <= rack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        pend_d    = pend_q | reinit;
        done_d    = done_q;
        haddr_d   = haddr_q;
        hwdata_d  = hwdata_q;
        rdata_d   = rdata_q;
        rack_d    = 1'b0;
        restart   = 1'b0;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        host_ack  = rack_q;
`ifdef HWAG_REGBUS_VERIFY_EN
        vdrain_d  = vdrain_q;
`endif

        case (state_q)
            S_LOAD: begin
                // While still in reset and for the first cycle after it,
                // run_q keeps the bus quiet; the load starts on that edge.
                bus_we    = run_q;
                bus_addr  = k_q;
                bus_wdata = run_q ? init_data : '0;
                if (reinit) begin
                    k_d     = '0;
                    pend_d  = 1'b0;
                    restart = 1'b1;
                end else if (run_q) begin
                    if (k_q == LAST_K) begin
`ifdef HWAG_REGBUS_VERIFY_EN
                        state_d  = S_VERIFY;
                        k_d      = '0;
                        vdrain_d = 1'b0;
`else
                        state_d  = S_IDLE;
                        done_d   = 1'b1;
`endif
                    end else begin
                        k_d = k_q + ONE_K;
                    end
                end
            end

`ifdef HWAG_REGBUS_VERIFY_EN
            S_VERIFY: begin
                if (reinit) begin
                    state_d  = S_LOAD;
                    k_d      = '0;
                    pend_d   = 1'b0;
                    vdrain_d = 1'b0;
                    restart  = 1'b1;
                end else if (vdrain_q) begin
                    // Last read's data is compared in this cycle.
                    vdrain_d = 1'b0;
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                end else begin
                    bus_re   = 1'b1;
                    bus_addr = k_q;
                    if (k_q == LAST_K) begin
                        vdrain_d = 1'b1;
                    end else begin
                        k_d = k_q + ONE_K;
                    end
                end
            end
`endif

            S_IDLE: begin
                if (pend_q || reinit) begin
                    state_d = S_LOAD;
                    k_d     = '0;
                    pend_d  = 1'b0;
                    done_d  = 1'b0;
                    restart = 1'b1;
                end else if (host_req && !rack_q) begin
                    // During a read-ack cycle the host still holds host_req;
                    // accepting it then would serve the same request twice.
                    haddr_d  = host_addr;
                    hwdata_d = host_wdata;
                    state_d  = host_we ? S_HWR : S_HRD;
                end
            end

            S_HWR: begin
                bus_we    = 1'b1;
                bus_addr  = haddr_q;
                bus_wdata = hwdata_q;
                host_ack  = 1'b1;
                state_d   = S_IDLE;
            end

            S_HRD: begin
                bus_re   = 1'b1;
                bus_addr = haddr_q;
                state_d  = S_HRD_WAIT;
            end

            S_HRD_WAIT: begin
                rdata_d = bus_rdata;
                rack_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_LOAD;
                k_d     = '0;
            end
        endcase
    end

`ifdef HWAG_REGBUS_VERIFY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vdrain_q <= 1'b0;
            chk_q    <= 1'b0;
            exp_q    <= '0;
            verr_q   <= 1'b0;
        end else begin
            vdrain_q <= vdrain_d;
            chk_q    <= chk_d;
            exp_q    <= exp_d;
            verr_q   <= verr_d;
        end
    end

    always_comb begin
        chk_d  = (state_q == S_VERIFY) && bus_re;
        exp_d  = init_data;
        verr_d = verr_q;
        if (restart) begin
            verr_d = 1'b0;
        end else if (chk_q && (state_q == S_VERIFY) && (bus_rdata != exp_q)) begin
            verr_d = 1'b1;
        end
    end

    assign verr = verr_q;
`else
    assign verr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/hwag_regbus_arb.md
HWAG_REGBUS_ARB -- requirements
Module: hwag_regbus_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, register address width.
REQ-002 SHALL have parameter DATA_W, default 16, register data width.
REQ-003 SHALL have parameter LAST_ADDR, default 130, highest register address loaded at boot.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port reinit  in  1  one-cycle pulse; restart boot load.
REQ-007 SHALL have port init_addr  out  ADDR_W  address to external default-value ROM.
REQ-008 SHALL have port init_data  in  DATA_W  combinational ROM data for init_addr.
REQ-009 SHALL have ports host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host (SPI-side) access request; held until host_ack.
REQ-010 SHALL have ports host_ack, host_rdata  out  1/DATA_W  one-cycle completion pulse; read data valid with ack.
REQ-011 SHALL have ports bus_addr, bus_wdata, bus_we, bus_re  out  ADDR_W/DATA_W/1/1  register-bus master toward hwag.
REQ-012 SHALL have port bus_rdata  in  DATA_W  register read data, valid the cycle after bus_re.
REQ-013 SHALL have ports init_done, verr  out  1/1  boot load complete; readback mismatch seen.

Function
REQ-014 SHALL implement states LOAD, VERIFY, IDLE, HWR, HRD, HRD_WAIT.
REQ-015 LOAD SHALL assert bus_we with bus_addr=init_addr=k, bus_wdata=init_data for k=0..LAST_ADDR, one address per cycle, no gaps.
REQ-016 After k=LAST_ADDR LOAD SHALL go to VERIFY (macro on) or IDLE (macro off).
REQ-017 init_done SHALL rise on the cycle IDLE is first entered and fall on the cycle after reinit is accepted.
REQ-018 IDLE SHALL accept host_req: host_we=1 -> HWR, host_we=0 -> HRD; host_addr/host_wdata captured at acceptance.
REQ-019 HWR SHALL drive bus_we=1 for exactly one cycle and pulse host_ack in that same cycle; return to IDLE.
REQ-020 HRD SHALL drive bus_re=1 one cycle; HRD_WAIT SHALL register bus_rdata into host_rdata and pulse host_ack; total read latency 3 cycles from acceptance.
REQ-021 host_req SHALL be ignored (no ack) in LOAD/VERIFY; a held request is served on IDLE entry.
REQ-022 reinit SHALL be latched as pending in any state; an in-flight host transaction SHALL complete first; pending reinit SHALL take priority over host_req in IDLE and enter LOAD at k=0.
REQ-023 reinit during LOAD/VERIFY SHALL restart at k=0.
REQ-024 bus_we and bus_re SHALL never be high in the same cycle; both low in IDLE.
REQ-025 Address counter SHALL stop at LAST_ADDR and never wrap.

Reset
REQ-026 Reset SHALL force state LOAD, k=0, reinit pending=0, init_done=0, verr=0, host_ack=0, host_rdata=0, bus_we=0, bus_re=0, bus_addr=0, bus_wdata=0.
REQ-027 Boot load SHALL begin on the first clock edge after rst deasserts; rst asserted mid-operation SHALL abort immediately.

Configuration
REQ-028 Macro HWAG_REGBUS_VERIFY_EN defined: VERIFY SHALL issue bus_re for k=0..LAST_ADDR, one per cycle, compare bus_rdata with the ROM value for address k-1 in the next cycle, set verr on any mismatch; verr sticky until reset or reinit.
REQ-029 Macro absent: VERIFY state and compare logic SHALL not exist; verr SHALL be tied 0.

Verification
REQ-030 Reset release, ROM[k]=k+1 -> 131 consecutive bus_we cycles addr 0..130 data 1..131; init_done high at cycle 131 (macro off) or 263 (macro on).
REQ-031 After init, host write addr 63 data 0x0007 -> single bus_we cycle addr 63 data 0x0007, host_ack same cycle.
REQ-032 Host read addr 70, bus model returns 0x0002 -> bus_re one cycle, host_ack with host_rdata=0x0002 three cycles after acceptance.
REQ-033 host_req held from reset -> no host_ack before init_done; served first cycle after IDLE entry.
REQ-034 reinit pulsed during HRD -> read completes with ack, then LOAD restarts at addr 0, init_done low.
REQ-035 Macro on, bus model corrupts addr 5 -> verr=1 at end of VERIFY, init_done still rises; reinit clears verr.
